uart_rx_stream_bridge: RTL and testbench
========================================

// Module: uart_rx_stream_bridge
// PURPOSE
//  Downstream stage of the Ibex demo system. Deserialises the SoC's uart_tx_o line and buffers the bytes in a FIFO.
//  Presents them on a valid/ready byte stream to the USB CDC transmit path of the fabric.
//  Lets firmware printf traffic reach the host over USB with no external UART.
// PARAMETERS
//  ClockFrequency  12_000_000  clk_sys_i frequency in Hz
//  BaudRate        115_200     line rate; ClksPerBit = ClockFrequency/BaudRate (integer div, 104 at defaults)
//  FifoDepth       16          byte FIFO entries; power of two, >= 2
// PORTS
//  clk_sys_i      in   1                   system clock
//  rst_sys_i      in   1                   asynchronous, active-high reset
//  uart_rx_i      in   1                   serial line, idle high; driven by SoC uart_tx_o
//  m_data_o       out  8                   head-of-FIFO byte
//  m_valid_o      out  1                   m_data_o valid
//  m_ready_i      in   1                   consumer accepts when m_valid_o & m_ready_i
//  level_o        out  $clog2(FifoDepth)+1 FIFO occupancy
//  frame_err_o    out  1                   1-cycle pulse: stop bit sampled low
//  parity_err_o   out  1                   1-cycle pulse: parity mismatch (see CONFIGURATION)
//  overflow_o     out  1                   1-cycle pulse: received byte dropped, FIFO full
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; FIFO empty; synchroniser flops preset to 1 (idle line).
//  - uart_rx_i passes a 2-flop synchroniser; all sampling uses the synchronised value rx_s.
//  - Bit counter counts 0..ClksPerBit-1 and wraps; mid-bit sample at count ClksPerBit/2.
//  - FSM:
//    IDLE: rx_s falling edge -> START, counter cleared.
//    START: at mid-bit, rx_s=0 -> DATA; rx_s=1 -> IDLE (glitch rejected, nothing pushed).
//    DATA: 8 bits sampled LSB first, one per ClksPerBit; after bit 7 -> STOP (or PARITY if enabled).
//    STOP: at mid-bit, rx_s=1 -> push byte, go IDLE. rx_s=0 -> frame_err_o pulse, byte discarded, go WAIT_IDLE.
//    WAIT_IDLE: stay until rx_s=1 (break condition), then IDLE.
//  - Next start edge is accepted from the stop-bit mid-sample onward; back-to-back frames supported.
//  - Push latency: byte enters FIFO on the cycle after the stop-bit mid-sample.
//    m_valid_o asserts on the following cycle (show-ahead, registered).
//  - Pop: m_valid_o & m_ready_i pops; next entry is visible the following cycle.
//    m_data_o holds stable while m_valid_o=1 and m_ready_i=0.
//  - Empty: m_valid_o=0; m_data_o don't-care. Pointers wrap modulo FifoDepth.
//  - Full + push, no pop: byte dropped, overflow_o pulses, FIFO contents unchanged.
//  - Full + push + pop same cycle: both performed, no overflow, level_o unchanged.
//  - Empty + push: no pop possible that cycle; level_o 0->1.
//  - level_o updates the cycle after push/pop; it is never > FifoDepth.
//  - Reset mid-frame or with data buffered: frame abandoned, FIFO flushed, m_valid_o=0 asynchronously.
// CONFIGURATION
//  - UART_RX_BRIDGE_PARITY_EN defined:
//    - Frame is start + 8 data + even parity + stop; PARITY state samples the parity bit at mid-bit.
//    - Mismatch: parity_err_o pulses at the stop mid-sample and the byte is discarded.
//    - A stop-bit error takes precedence; only frame_err_o pulses.
//  - Not defined: 8N1 frames, no PARITY state, parity_err_o tied 0.
// TESTING
//  1. Reset asserted -> m_valid_o=0, level_o=0, all error pulses 0.
//  2. Send 0xA5 8N1 at 104 clk/bit, m_ready_i=1.
//     -> m_data_o=0xA5 with m_valid_o high for 1 cycle, 2 cycles after stop mid-sample.
//  3. m_ready_i=0; send 17 bytes 0x00..0x10 back-to-back, FifoDepth=16.
//     -> level_o=16; one overflow_o pulse on byte 0x10; draining yields 0x00..0x0F in order.
//  4. 20-cycle low glitch on idle line -> no push, no frame_err_o, FSM back to IDLE.
//  5. Frame 0x3C with stop bit held low for 2 bit times -> frame_err_o pulse, level_o=0.
//     Following valid 0x55 is received correctly.
//  6. With UART_RX_BRIDGE_PARITY_EN: 0x07 with parity=0 (wrong) -> parity_err_o pulse, dropped.
//     0x07 with parity=1 -> delivered.

Source files
------------

// File: rtl/uart_rx_stream_bridge.sv
// ============================================================================
// Module   : uart_rx_stream_bridge
// Brief    : UART receiver feeding a show-ahead byte FIFO with a valid/ready
//            output stream. Define UART_RX_BRIDGE_PARITY_EN for 8E1 frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_stream_bridge #(
    parameter int ClockFrequency = 12_000_000,
    parameter int BaudRate       = 115_200,
    parameter int FifoDepth      = 16
) (
    input  logic                       clk_sys_i,
    input  logic                       rst_sys_i,
    input  logic                       uart_rx_i,
    output logic [7:0]                 m_data_o,
    output logic                       m_valid_o,
    input  logic                       m_ready_i,
    output logic [$clog2(FifoDepth):0] level_o,
    output logic                       frame_err_o,
    output logic                       parity_err_o,
    output logic                       overflow_o
);

    localparam int                 c_CLKS_PER_BIT = ClockFrequency / BaudRate;
    localparam int                 c_CNT_W        = $clog2(c_CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX      = c_CNT_W'(c_CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MID      = c_CNT_W'(c_CLKS_PER_BIT / 2);
    localparam int                 c_AW           = $clog2(FifoDepth);
    localparam logic [c_AW:0]      c_FULL_LEVEL   = (c_AW + 1)'(FifoDepth);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_e;

    logic               rx_meta_q, rx_s_q, rx_prev_q;
    state_e             state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               push_q, push_d;
    logic               frame_err_q, frame_err_d;
    logic               w_mid;
`ifdef UART_RX_BRIDGE_PARITY_EN
    logic               par_q, par_d;
    logic               parity_err_q, parity_err_d;
`endif

    // Synchroniser and edge-detect history preset high so reset looks like an idle line.
    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx_i;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign w_mid = (cnt_q == c_CNT_MID);

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            push_q       <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_BRIDGE_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            push_q       <= push_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_BRIDGE_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = (cnt_q == c_CNT_MAX) ? '0 : cnt_q + 1'b1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        push_d       = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RX_BRIDGE_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (!rx_s_q && rx_prev_q) state_d = S_START;
            end
            S_START: begin
                if (w_mid) state_d = rx_s_q ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_mid) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_BRIDGE_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_BRIDGE_PARITY_EN
            S_PARITY: begin
                if (w_mid) begin
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_mid) begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
`ifdef UART_RX_BRIDGE_PARITY_EN
                        if (^{shift_q, par_q}) parity_err_d = 1'b1;
                        else                   push_d       = 1'b1;
`else
                        push_d = 1'b1;
`endif
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Byte FIFO; shift_q is stable during the push cycle so it is written directly.
    logic [7:0]      mem_q [FifoDepth];
    logic [c_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [c_AW:0]   count_q;
    logic            overflow_q;
    logic            w_full, w_pop, w_push;

    assign w_full = (count_q == c_FULL_LEVEL);
    assign w_pop  = (count_q != '0) && m_ready_i;
    assign w_push = push_q && (!w_full || w_pop);

    always_ff @(posedge clk_sys_i) begin
        if (w_push) mem_q[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            overflow_q <= push_q && w_full && !w_pop;
        end
    end

    assign m_valid_o   = (count_q != '0);
    assign m_data_o    = mem_q[rd_ptr_q];
    assign level_o     = count_q;
    assign frame_err_o = frame_err_q;
    assign overflow_o  = overflow_q;
`ifdef UART_RX_BRIDGE_PARITY_EN
    assign parity_err_o = parity_err_q;
`else
    assign parity_err_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_stream_bridge.sv
// ============================================================================
// Module   : tb_uart_rx_stream_bridge
// Brief    : Directed self-checking bench for uart_rx_stream_bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx_stream_bridge;

    localparam int c_CPB = 12_000_000 / 115_200;
`ifdef UART_RX_BRIDGE_PARITY_EN
    localparam int c_STOP_IDX = 10;
`else
    localparam int c_STOP_IDX = 9;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic [4:0] level;
    logic       ferr, perr, ovf;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         n_ferr = 0, n_perr = 0, n_ovf = 0;
    int         first_valid = -1;
    int         valid_cycles = 0;
    int         t_frame = 0;
    logic [7:0] rxq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_stream_bridge dut (
        .clk_sys_i    (clk),
        .rst_sys_i    (rst),
        .uart_rx_i    (rx),
        .m_data_o     (m_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (ready),
        .level_o      (level),
        .frame_err_o  (ferr),
        .parity_err_o (perr),
        .overflow_o   (ovf)
    );

    // Stream and pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (m_valid && ready) rxq.push_back(m_data);
            if (ferr) n_ferr++;
            if (perr) n_perr++;
            if (ovf)  n_ovf++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par,
                              input int stop_cycles, input logic stop_val);
        t_frame = cyc;
        rx = 1'b0;
        wait_cyc(c_CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(c_CPB);
        end
`ifdef UART_RX_BRIDGE_PARITY_EN
        rx = par;
        wait_cyc(c_CPB);
`endif
        rx = stop_val;
        wait_cyc(stop_cycles);
        rx = 1'b1;
    endtask

    function automatic logic [31:0] head(input int idx);
        return (rxq.size() > idx) ? 32'(rxq[idx]) : 32'hDEAD_BEEF;
    endfunction

    initial begin
        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b1;
        wait_cyc(5);
        chk("reset_valid", 32'(m_valid), 0);
        chk("reset_level", 32'(level), 0);
        chk("reset_ferr", 32'(ferr), 0);
        chk("reset_perr", 32'(perr), 0);
        chk("reset_ovf", 32'(ovf), 0);
        rst = 1'b0;
        wait_cyc(5);

        // Single byte with consumer ready: exact latency and one-cycle valid.
        rxq.delete();
        first_valid  = -1;
        valid_cycles = 0;
        send_frame(8'hA5, ^8'hA5, c_CPB, 1'b1);
        wait_cyc(50);
        chk("a5_count", rxq.size(), 1);
        chk("a5_data", head(0), 32'hA5);
        chk("a5_latency", first_valid, t_frame + 57 + c_CPB * c_STOP_IDX);
        chk("a5_valid_len", valid_cycles, 1);

        // Fill to full with the consumer stalled, then overflow on the 17th byte.
        ready = 1'b0;
        for (int i = 0; i < 16; i++) send_frame(8'(i), ^8'(i), c_CPB, 1'b1);
        chk("fill_level", 32'(level), 16);
        chk("fill_ovf", n_ovf, 0);
        chk("fill_valid", 32'(m_valid), 1);
        chk("fill_head", 32'(m_data), 0);
        send_frame(8'h10, ^8'h10, c_CPB, 1'b1);
        wait_cyc(20);
        chk("ovf_count", n_ovf, 1);
        chk("ovf_level", 32'(level), 16);
        chk("ovf_head", 32'(m_data), 0);
        rxq.delete();
        ready = 1'b1;
        wait_cyc(30);
        ready = 1'b0;
        chk("drain_count", rxq.size(), 16);
        for (int i = 0; i < 16; i++) chk($sformatf("drain_%0d", i), head(i), 32'(i));
        chk("drain_level", 32'(level), 0);

        // Short low glitch on the idle line is rejected.
        rxq.delete();
        ready = 1'b1;
        rx = 1'b0;
        wait_cyc(20);
        rx = 1'b1;
        wait_cyc(300);
        chk("glitch_level", 32'(level), 0);
        chk("glitch_rx", rxq.size(), 0);
        chk("glitch_ferr", n_ferr, 0);

        // Stop bit held low for two bit times, then a clean frame.
        send_frame(8'h3C, ^8'h3C, 2 * c_CPB, 1'b0);
        wait_cyc(200);
        chk("ferr_count", n_ferr, 1);
        chk("ferr_level", 32'(level), 0);
        chk("ferr_rx", rxq.size(), 0);
        send_frame(8'h55, ^8'h55, c_CPB, 1'b1);
        wait_cyc(50);
        chk("after_ferr_count", rxq.size(), 1);
        chk("after_ferr_data", head(0), 32'h55);

`ifdef UART_RX_BRIDGE_PARITY_EN
        rxq.delete();
        send_frame(8'h07, 1'b0, c_CPB, 1'b1);
        wait_cyc(50);
        chk("perr_count", n_perr, 1);
        chk("perr_rx", rxq.size(), 0);
        send_frame(8'h07, 1'b1, c_CPB, 1'b1);
        wait_cyc(50);
        chk("par_ok_count", rxq.size(), 1);
        chk("par_ok_data", head(0), 32'h07);
        chk("par_ok_perr", n_perr, 1);
`else
        chk("no_parity_perr", n_perr, 0);
`endif

        // Asynchronous reset with a byte buffered flushes the FIFO immediately.
        ready = 1'b0;
        send_frame(8'h5A, ^8'h5A, c_CPB, 1'b1);
        wait_cyc(10);
        chk("pre_rst_valid", 32'(m_valid), 1);
        chk("pre_rst_data", 32'(m_data), 32'h5A);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(m_valid), 0);
        chk("async_rst_level", 32'(level), 0);
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(5);
        chk("post_rst_valid", 32'(m_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
